flash_read_arbiter: RTL and testbench

//  Shares the single DSPI flash byte reader between NUM_REQ clients (ROM loader, cart/tape image fetch, OSD).

---
 rtl/flash_arb_pkg.sv | 26 ++
 rtl/flash_rr_pick.sv | 50 +++++
 rtl/flash_read_arbiter.sv | 175 +++++++++++++++++
 tb/tb_flash_read_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter: FSM state encoding,
// address/data widths, the byte returned on an aborted read, and a small
// index helper used by the round-robin picker.
package flash_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;

    // Byte handed back to a client whose transfer was abandoned on timeout
    localparam logic [DATA_W-1:0] ERR_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STROBE    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4,
        ABORT     = 3'd5
    } arb_state_e;

    // Slot index reached by stepping 'step' places past 'base' in a ring of 'n'
    function automatic int ring_step(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Combinational round-robin picker. Given the pending request vector and the
// one-hot previous owner, returns the one-hot next owner: the first requester
// found scanning upward from the slot after the previous owner, wrapping.
// The previous owner is checked last, so it cannot re-win while anyone else
// is waiting. Output is all zeros when nothing is requested.
module flash_rr_pick
    import flash_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_idx_s;
    logic [IDX_W-1:0] scan_idx_s;
    logic             found_s;

    // Convert the one-hot previous owner to an index; an empty vector maps to the top slot
    always_comb begin
        last_idx_s = IDX_W'(N - 1);
        for (int i = 0; i < N; i++) begin
            if (last[i]) begin
                last_idx_s = IDX_W'(i);
            end else begin
                last_idx_s = last_idx_s;
            end
        end
    end

    // Scan the ring starting just after the previous owner and take the first requester
    always_comb begin
        pick       = '0;
        found_s    = 1'b0;
        scan_idx_s = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx_s = IDX_W'(ring_step(int'(last_idx_s), k, N));
            if (!found_s && req[scan_idx_s]) begin
                pick[scan_idx_s] = 1'b1;
                found_s          = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one DSPI flash byte reader between NUM_REQ clients. Round-robin
// arbitration picks an owner, its address is latched, the reader is strobed
// via flash_cs for CS_HOLD cycles, and the returned byte (or ERR_DATA on a
// timeout) is handed back with a one-cycle rd_valid bit for that owner.
// All outputs are registered.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CS_HOLD = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]         flash_addr,
    output logic                      flash_cs,
    input  logic [DATA_W-1:0]         flash_dout,
    input  logic                      flash_busy,
    input  logic                      flash_ready
);

    // One counter serves both the strobe width and the wait timeouts
    localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CS_LAST  = CNT_W'(CS_HOLD - 1);
    // Previous owner after reset is the top client, so client 0 wins first
    localparam logic [NUM_REQ-1:0] LAST_RST = NUM_REQ'(1'b1) << (NUM_REQ - 1);

    arb_state_e          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [NUM_REQ-1:0]  last_grant_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic [NUM_REQ-1:0]  rd_valid_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_err_r;
    logic [ADDR_W-1:0]   flash_addr_r;
    logic                flash_cs_r;
    logic [NUM_REQ-1:0]  pick_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    logic                start_s;

    flash_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req  (req_valid),
        .last (last_grant_r),
        .pick (pick_s)
    );

    // Route the picked client's address; pick is one-hot so an OR-reduce is a clean mux
    always_comb begin
        addr_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_s[i]) begin
                addr_sel_s = addr_sel_s | req_addr[ADDR_W*i +: ADDR_W];
            end else begin
                addr_sel_s = addr_sel_s;
            end
        end
    end

    // Saturating increment so a stuck reader can never wrap the timeout counter
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 1'b1;
        end
    end

    // A new transfer may start only once the reader has finished initialising
    always_comb begin
        if (flash_ready && (|req_valid)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Arbiter FSM with registered strobe, ownership and delivery outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            last_grant_r <= LAST_RST;
            grant_r      <= '0;
            rd_valid_r   <= '0;
            rd_data_r    <= '0;
            rd_err_r     <= 1'b0;
            flash_addr_r <= '0;
            flash_cs_r   <= 1'b0;
        end else begin
            // Delivery flags are single-cycle pulses unless re-asserted below
            rd_valid_r <= '0;
            rd_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        flash_addr_r <= addr_sel_s;
                        flash_cs_r   <= 1'b1;
                        cnt_r        <= '0;
                        state_r      <= STROBE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STROBE: begin
                    if (cnt_r == CS_LAST) begin
                        flash_cs_r <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= WAIT_BUSY;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WAIT_BUSY: begin
                    // Busy already high (reader occupied elsewhere) is taken as started
                    if (flash_busy) begin
                        cnt_r   <= '0;
                        state_r <= WAIT_DONE;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= ABORT;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WAIT_DONE: begin
                    if (!flash_busy) begin
                        state_r <= DELIVER;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= ABORT;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                DELIVER: begin
                    rd_data_r  <= flash_dout;
                    rd_valid_r <= grant_r;
                    grant_r    <= '0;
                    state_r    <= IDLE;
                end
                ABORT: begin
                    rd_data_r  <= ERR_DATA;
                    rd_valid_r <= grant_r;
                    rd_err_r   <= 1'b1;
                    grant_r    <= '0;
                    state_r    <= IDLE;
                end
                default: begin
                    flash_cs_r <= 1'b0;
                    grant_r    <= '0;
                    cnt_r      <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_err     = rd_err_r;
    assign grant      = grant_r;
    assign flash_addr = flash_addr_r;
    assign flash_cs   = flash_cs_r;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: a small flash reader model plus a
// table of single-client transfers, and hand-written sequences for reset in
// the middle of a transfer, three-way contention and reader not ready.
module tb_flash_read_arbiter;

    localparam int NUM_REQ = 3;
    localparam int CS_HOLD = 2;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [71:0] req_addr;
    logic [2:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic [2:0]  grant;
    logic [23:0] flash_addr;
    logic        flash_cs;
    logic [7:0]  flash_dout = 8'h00;
    logic        flash_busy = 1'b0;
    logic        flash_ready;

    int total = 0;
    int bad   = 0;

    flash_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CS_HOLD (CS_HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .grant       (grant),
        .flash_addr  (flash_addr),
        .flash_cs    (flash_cs),
        .flash_dout  (flash_dout),
        .flash_busy  (flash_busy),
        .flash_ready (flash_ready)
    );

    always #5 clk = ~clk;

    // Byte the model reader returns for an address
    function automatic logic [7:0] data_of(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Reader model: sees the cs rising edge one cycle late, busy for 4 cycles, then data
    logic [7:0]  rtimer   = 8'd0;
    logic        cs_q     = 1'b0;
    logic        no_busy  = 1'b0;
    int          rd_edges = 0;
    logic [23:0] lat_addr = 24'h0;
    always @(posedge clk) begin
        cs_q <= flash_cs;
        if (flash_cs && !cs_q) begin
            rd_edges <= rd_edges + 1;
            if (!no_busy) begin
                rtimer   <= 8'd1;
                lat_addr <= flash_addr;
            end
        end else if (rtimer != 8'd0) begin
            if (rtimer == 8'd6) begin
                flash_busy <= 1'b0;
                flash_dout <= data_of(lat_addr);
                rtimer     <= 8'd0;
            end else begin
                flash_busy <= (rtimer >= 8'd2);
                rtimer     <= rtimer + 8'd1;
            end
        end
    end

    // Strobe monitor: width of every cs pulse, shortest low gap, delivery count
    int   hi_len   = 0;
    int   lo_len   = 0;
    int   min_gap  = 1000;
    int   bad_runs = 0;
    int   n_deliv  = 0;
    logic cs_prev  = 1'b0;
    logic seen     = 1'b0;
    always @(negedge clk) begin
        if (flash_cs) begin
            hi_len <= hi_len + 1;
            lo_len <= 0;
            if (!cs_prev && seen && lo_len < min_gap) min_gap <= lo_len;
        end else begin
            hi_len <= 0;
            lo_len <= lo_len + 1;
            if (cs_prev) begin
                if (hi_len != CS_HOLD) bad_runs <= bad_runs + 1;
                seen <= 1'b1;
            end
        end
        cs_prev <= flash_cs;
        if (rd_valid != 3'b000) n_deliv <= n_deliv + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic        nobusy;
        logic        scramble;
        logic [2:0]  exp_grant;
        logic [23:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];
    vec_t cont[4];

    // One transfer: raise the request, check the strobe and the delivery
    task automatic run_txn(input vec_t v, input int lat_exp);
        int cyc;
        bit got_cs;
        bit done;
        cyc     = 0;
        got_cs  = 1'b0;
        done    = 1'b0;
        no_busy = v.nobusy;
        req_valid = v.req;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (flash_cs && !got_cs) begin
                got_cs = 1'b1;
                chk("grant_at_strobe", 32'(grant), 32'(v.exp_grant));
                chk("flash_addr", 32'(flash_addr), 32'(v.exp_addr));
                if (v.scramble) req_addr[23:0] = 24'h777777;
            end
            if (rd_valid != 3'b000) done = 1'b1;
        end
        total++;
        if (!done || !got_cs) begin
            bad++;
            $display("FAIL txn_wait: done=%0d strobe=%0d after %0d cycles", done, got_cs, cyc);
        end
        chk("rd_valid", 32'(rd_valid), 32'(v.exp_grant));
        chk("rd_data", 32'(rd_data), 32'(v.exp_data));
        chk("rd_err", 32'(rd_err), 32'(v.exp_err));
        chk("grant_released", 32'(grant), 32'd0);
        if (lat_exp > 0) chk("latency", 32'(cyc), 32'(lat_exp));
        req_valid = 3'b000;
        req_addr[23:0] = 24'h00A000;
        no_busy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int e0;

        //            req     nobusy scram  grant   addr          data   err
        vecs[0] = '{3'b001, 1'b0, 1'b0, 3'b001, 24'h00A000, 8'h5A, 1'b0};
        vecs[1] = '{3'b100, 1'b0, 1'b0, 3'b100, 24'h00B0C3, 8'h99, 1'b0};
        vecs[2] = '{3'b010, 1'b0, 1'b0, 3'b010, 24'h123456, 8'h1E, 1'b0};
        vecs[3] = '{3'b001, 1'b0, 1'b1, 3'b001, 24'h00A000, 8'h5A, 1'b0};
        vecs[4] = '{3'b001, 1'b1, 1'b0, 3'b001, 24'h00A000, 8'hFF, 1'b1};
        vecs[5] = '{3'b110, 1'b0, 1'b0, 3'b010, 24'h123456, 8'h1E, 1'b0};
        vecs[6] = '{3'b101, 1'b0, 1'b0, 3'b100, 24'h00B0C3, 8'h99, 1'b0};

        cont[0] = '{3'b111, 1'b0, 1'b0, 3'b001, 24'h00A000, 8'h5A, 1'b0};
        cont[1] = '{3'b111, 1'b0, 1'b0, 3'b010, 24'h123456, 8'h1E, 1'b0};
        cont[2] = '{3'b111, 1'b0, 1'b0, 3'b100, 24'h00B0C3, 8'h99, 1'b0};
        cont[3] = '{3'b111, 1'b0, 1'b0, 3'b001, 24'h00A000, 8'h5A, 1'b0};

        reset       = 1'b1;
        req_valid   = 3'b000;
        req_addr    = {24'h00B0C3, 24'h123456, 24'h00A000};
        flash_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_flash_addr", 32'(flash_addr), 32'd0);
        chk("rst_flash_cs", 32'(flash_cs), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single-client transfers; first one also checks latency (1+2+6+1)
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], (i == 0) ? 10 : 0);
        end

        // Reset while the reader is busy: outputs clear at once, client 0 wins afterwards
        req_valid = 3'b001;
        n = 0;
        while (!flash_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", 32'(flash_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_cs", 32'(flash_cs), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_flash_addr", 32'(flash_addr), 32'd0);
        req_valid = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Three clients held high: strict rotation starting from client 0
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (rd_valid == 3'b000 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("cont_rd_valid", 32'(rd_valid), 32'(cont[k].exp_grant));
            chk("cont_rd_data", 32'(rd_data), 32'(cont[k].exp_data));
            chk("cont_rd_err", 32'(rd_err), 32'(cont[k].exp_err));
        end
        req_valid = 3'b000;
        repeat (12) @(negedge clk);

        // Reader not ready: request pends without any strobe, then is served once
        flash_ready = 1'b0;
        e0 = rd_edges;
        req_valid = 3'b010;
        repeat (100) @(negedge clk);
        chk("notready_edges", 32'(rd_edges - e0), 32'd0);
        chk("notready_grant", 32'(grant), 32'd0);
        flash_ready = 1'b1;
        run_txn(vecs[2], 0);
        chk("ready_one_edge", 32'(rd_edges - e0), 32'd1);

        // Strobe shape over the whole run
        chk("cs_min_gap_ge2", 32'(min_gap >= 2), 32'd1);
        chk("cs_width_bad", 32'(bad_runs), 32'd0);
        chk("edges_vs_deliv", 32'(rd_edges), 32'(n_deliv + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
